// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Each port gets a one-entry response buffer drained by a valid/ready handshake.
module alu_share_arbiter #(
  parameter int INIT_PRIO = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [3:0]       req0_aluc,
  output logic             req0_ready,
  output logic             rsp0_valid,
  output logic [31:0]      rsp0_r,
  output logic [3:0]       rsp0_flags,
  input  logic             rsp0_ready,

  input  logic             req1_valid,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [3:0]       req1_aluc,
  output logic             req1_ready,
  output logic             rsp1_valid,
  output logic [31:0]      rsp1_r,
  output logic [3:0]       rsp1_flags,
  input  logic             rsp1_ready,

  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_aluc,
  input  logic [31:0]      alu_r,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_negative,
  input  logic             alu_overflow,

  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  localparam logic PRIO_RST = (INIT_PRIO != 0);

  logic             elig0, elig1;
  logic             gnt0, gnt1;
  logic [3:0]       flags_w;

  logic             prio_q, prio_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic [31:0]      rsp0_r_q, rsp0_r_d;
  logic [3:0]       rsp0_flags_q, rsp0_flags_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic [31:0]      rsp1_r_q, rsp1_r_d;
  logic [3:0]       rsp1_flags_q, rsp1_flags_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // A full buffer being drained this cycle can accept a new result.
  assign elig0   = req0_valid && (!rsp0_valid_q || rsp0_ready);
  assign elig1   = req1_valid && (!rsp1_valid_q || rsp1_ready);
  assign gnt0    = elig0 && (!elig1 || (prio_q == 1'b0));
  assign gnt1    = elig1 && (!elig0 || (prio_q == 1'b1));
  assign flags_w = {alu_zero, alu_carry, alu_negative, alu_overflow};

  always_comb begin
    alu_a    = 32'd0;
    alu_b    = 32'd0;
    alu_aluc = 4'd0;
    if (gnt0) begin
      alu_a    = req0_a;
      alu_b    = req0_b;
      alu_aluc = req0_aluc;
    end else if (gnt1) begin
      alu_a    = req1_a;
      alu_b    = req1_b;
      alu_aluc = req1_aluc;
    end
  end

  always_comb begin
    rsp0_valid_d = rsp0_valid_q;
    rsp0_r_d     = rsp0_r_q;
    rsp0_flags_d = rsp0_flags_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp1_r_d     = rsp1_r_q;
    rsp1_flags_d = rsp1_flags_q;
    prio_d       = prio_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;

    if (gnt0) begin
      rsp0_valid_d = 1'b1;
      rsp0_r_d     = alu_r;
      rsp0_flags_d = flags_w;
      prio_d       = 1'b1;
      if (cnt0_q != '1) cnt0_d = cnt0_q + CNT_W'(1);
    end else if (rsp0_ready) begin
      rsp0_valid_d = 1'b0;
    end

    if (gnt1) begin
      rsp1_valid_d = 1'b1;
      rsp1_r_d     = alu_r;
      rsp1_flags_d = flags_w;
      prio_d       = 1'b0;
      if (cnt1_q != '1) cnt1_d = cnt1_q + CNT_W'(1);
    end else if (rsp1_ready) begin
      rsp1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q       <= PRIO_RST;
      rsp0_valid_q <= 1'b0;
      rsp0_r_q     <= 32'd0;
      rsp0_flags_q <= 4'd0;
      rsp1_valid_q <= 1'b0;
      rsp1_r_q     <= 32'd0;
      rsp1_flags_q <= 4'd0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      prio_q       <= prio_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_r_q     <= rsp0_r_d;
      rsp0_flags_q <= rsp0_flags_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_r_q     <= rsp1_r_d;
      rsp1_flags_q <= rsp1_flags_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp0_r     = rsp0_r_q;
  assign rsp0_flags = rsp0_flags_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp1_r     = rsp1_r_q;
  assign rsp1_flags = rsp1_flags_q;
  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;

endmodule
